// File: rtl/seq_detect_moore.sv
// seq_detect_moore: parametrised Moore serial pattern detector on the falling clock edge.
// Optional saturating match counter built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detect_moore #(
    parameter int            LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter bit            OVERLAP = 1'b1,
    parameter int            CNT_W   = 8,
    localparam int           FW      = $clog2(LEN + 1)
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             EN,
    input  logic             CLR,
    input  logic             I,
    output logic             Y,
    output logic [FW-1:0]    FILL,
    output logic [CNT_W-1:0] MATCH_CNT
);
    logic [LEN-1:0] h, h_nxt;
    logic [FW-1:0]  fill_nxt;
    logic           y_nxt;

    assign Y = (FILL == FW'(LEN)) && (h == PATTERN);

    always_comb begin
        h_nxt    = h;
        fill_nxt = FILL;
        if (CLR) begin
            h_nxt    = '0;
            fill_nxt = '0;
        end else if (EN && !OVERLAP && Y) begin
            h_nxt    = {{(LEN-1){1'b0}}, I};
            fill_nxt = FW'(1);
        end else if (EN) begin
            h_nxt    = {h[LEN-2:0], I};
            fill_nxt = (FILL == FW'(LEN)) ? FILL : FILL + FW'(1);
        end
        // a held match (EN low) or a clear never counts as a new match
        y_nxt = EN && !CLR && (fill_nxt == FW'(LEN)) && (h_nxt == PATTERN);
    end

    always_ff @(negedge CLK or negedge RES) begin
        if (!RES) begin
            h    <= '0;
            FILL <= '0;
        end else begin
            h    <= h_nxt;
            FILL <= fill_nxt;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    always_ff @(negedge CLK or negedge RES) begin
        if (!RES)
            MATCH_CNT <= '0;
        else if (CLR)
            MATCH_CNT <= '0;
        else if (y_nxt && (MATCH_CNT != {CNT_W{1'b1}}))
            MATCH_CNT <= MATCH_CNT + CNT_W'(1);
    end
`else
    logic unused_y_nxt;
    assign unused_y_nxt = y_nxt;
    assign MATCH_CNT    = '0;
`endif
endmodule

// File: tb/tb_seq_detect_moore.sv
// tb_seq_detect_moore: directed vectors for three detector configurations sharing one input stream.
module tb_seq_detect_moore;
`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, i = 1'b0;
    int   n_vec = 0, n_err = 0;

    logic       ov_y, no_y, wd_y;
    logic [1:0] ov_fill, no_fill;
    logic [3:0] wd_fill;
    logic [7:0] ov_cnt, no_cnt;
    logic [1:0] wd_cnt;

    always #5 clk = ~clk;

    seq_detect_moore u_ov (.CLK(clk), .RES(rst_n), .EN(en), .CLR(clr), .I(i),
                           .Y(ov_y), .FILL(ov_fill), .MATCH_CNT(ov_cnt));
    seq_detect_moore #(.OVERLAP(1'b0)) u_no (.CLK(clk), .RES(rst_n), .EN(en), .CLR(clr), .I(i),
                           .Y(no_y), .FILL(no_fill), .MATCH_CNT(no_cnt));
    seq_detect_moore #(.LEN(8), .PATTERN(8'hFF), .CNT_W(2), .OVERLAP(1'b1)) u_wd (
                           .CLK(clk), .RES(rst_n), .EN(en), .CLR(clr), .I(i),
                           .Y(wd_y), .FILL(wd_fill), .MATCH_CNT(wd_cnt));

    function automatic int cexp(input int n);
        return CNT_ON ? n : 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive away from the falling edge, then let it land and settle
    task automatic step(input logic e, input logic c, input logic d);
        @(posedge clk);
        en = e; clr = c; i = d;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] ov_bits   = 5'b10101;
        logic [4:0] ov_y_exp  = 5'b00101;
        logic [6:0] no_bits   = 7'b1010101;
        logic [6:0] no_y_exp  = 7'b0010001;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_y", ov_y, 0);
        chk("rst_fill", ov_fill, 0);
        chk("rst_cnt", ov_cnt, 0);
        @(posedge clk);
        rst_n = 1'b1;

        // reset mid-stream
        step(1, 0, 1);
        chk("mid_fill1", ov_fill, 1);
        step(1, 0, 0);
        chk("mid_fill2", ov_fill, 2);
        rst_n = 1'b0;
        #1;
        chk("async_fill", ov_fill, 0);
        chk("async_y", ov_y, 0);
        rst_n = 1'b1;
        step(1, 0, 1);
        step(1, 0, 0);
        chk("post_rst_y2", ov_y, 0);
        step(1, 0, 1);
        chk("post_rst_y3", ov_y, 1);
        chk("post_rst_cnt", ov_cnt, cexp(1));

        // clear together with enable: bit discarded
        step(1, 1, 1);
        chk("clr_y", ov_y, 0);
        chk("clr_fill", ov_fill, 0);
        chk("clr_cnt", ov_cnt, 0);

        // overlapping
        for (int k = 0; k < 5; k++) begin
            step(1, 0, ov_bits[4-k]);
            chk($sformatf("ov_y%0d", k + 1), ov_y, int'(ov_y_exp[4-k]));
        end
        chk("ov_cnt", ov_cnt, cexp(2));

        // non-overlapping
        step(1, 1, 0);
        for (int k = 0; k < 7; k++) begin
            step(1, 0, no_bits[6-k]);
            chk($sformatf("no_y%0d", k + 1), no_y, int'(no_y_exp[6-k]));
        end
        chk("no_cnt", no_cnt, cexp(2));

        // stall preserves partial match
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1);
        chk("stall_fill", ov_fill, 2);
        chk("stall_y", ov_y, 0);
        step(1, 0, 1);
        chk("stall_match", ov_y, 1);
        chk("stall_cnt", ov_cnt, cexp(1));
        step(0, 0, 0);
        chk("hold_y", ov_y, 1);
        chk("hold_cnt", ov_cnt, cexp(1));
        step(1, 1, 1);
        chk("clr2_y", ov_y, 0);
        chk("clr2_fill", ov_fill, 0);
        chk("clr2_cnt", ov_cnt, 0);

        // wide all-ones pattern with a 2-bit saturating counter
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 1);
            chk($sformatf("wd_y%0d", k), wd_y, (k >= 8) ? 1 : 0);
            chk($sformatf("wd_fill%0d", k), wd_fill, (k < 8) ? k : 8);
            chk($sformatf("wd_cnt%0d", k), wd_cnt, cexp((k < 8) ? 0 : ((k - 7 > 3) ? 3 : k - 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_detect_moore.md
# seq_detect_moore

Parametrised Moore-style serial sequence detector: a generalised successor to the team's fixed 2-flop "101" detector. It samples one serial bit `I` per enabled clock and raises `Y` while the most recent `LEN` accepted bits equal `PATTERN`. Overlapping or non-overlapping matching is selected by parameter, and an optional saturating match counter is included. It sits between a serial data source and control logic that needs a registered, glitch-free match flag.

## Interface
- `LEN`, 3: pattern length in bits; legal range 2..16.
- `PATTERN`, 3'b101: `LEN`-bit target; MSB is the oldest bit, LSB the newest.
- `OVERLAP`, 1: 1 allows overlapping matches; 0 restarts detection after each match.
- `CNT_W`, 8: match counter width; legal range 1..16.
- `CLK`  in  1  clock; all state updates on the falling edge, consistent with the codebase's flops.
- `RES`  in  1  reset; asynchronous and active-low.
- `EN`  in  1  sample enable; `I` is accepted only when high.
- `CLR`  in  1  synchronous clear of history, fill level and counter.
- `I`  in  1  serial data bit.
- `Y`  out  1  match flag; a Moore output decoded from registered state only.
- `FILL`  out  $clog2(LEN+1)  count of valid history bits, 0..`LEN`.
- `MATCH_CNT`  out  `CNT_W`  number of matches, saturating.

## Operation
- State:
  - history shift register `H[LEN-1:0]`
  - fill counter `FILL`
  - `MATCH_CNT`
- `Y = (FILL == LEN) && (H == PATTERN)`.
  - `Y` is purely combinational from state and never depends on `I`, `EN` or `CLR`.
- Each falling edge, in priority order:
  1. `CLR=1`: `H <= 0`, `FILL <= 0`, `MATCH_CNT <= 0`.
  2. `EN=0`: hold all state.
  3. `EN=1`, and `OVERLAP=0` and `Y=1`: restart; `H <= {0.., I}`, `FILL <= 1`.
  4. `EN=1`, otherwise: `H <= {H[LEN-2:0], I}`, `FILL <= min(FILL+1, LEN)`.
- Counter: increments by 1 on every edge where the next state decodes `Y=1`, via step 3 or 4.
  - Saturates at `2^CNT_W-1`; no wrap.
  - A held `Y` (`EN=0`) does not count again.
- Overlap: with `OVERLAP=1`, consecutive matches may share bits. For example, "10101" with `PATTERN`=101 matches after bits 3 and 5.
- Non-overlap: with `OVERLAP=0`, the bit accepted while `Y=1` becomes the first bit of a fresh window.
- Patterns of all zeros are legal. History zero-fill never produces a false match because `FILL` gates `Y`.

## Timing
- Reset values while `RES=0`: `H=0`, `FILL=0`, `MATCH_CNT=0`, `Y=0`.
- `RES` assertion clears state immediately, without waiting for `CLK`, including mid-sequence. `Y` falls asynchronously.
- First accepted edge after `RES` deassertion: state updates normally; no extra dead cycle.
- Latency: the bit accepted at falling edge k completing a match drives `Y=1` from edge k until the next state-changing edge.
- Minimum first-match latency is `LEN` enabled edges after reset or `CLR`.
- `CLR` and `EN` high together: `CLR` wins and the bit is discarded.
- A stall (`EN=0`) of any length preserves a partial match; detection resumes seamlessly.

## Configuration
- `SEQDET_MATCH_CNT_EN`
  - Defined: the `MATCH_CNT` register and increment logic are built as described above.
  - Undefined: no counter register is built; the `MATCH_CNT` port remains and is driven constant 0.
  - Detection behaviour is identical in both builds.

## Test plan
- Reset mid-stream: defaults, `EN=1`, feed 1,0 then drop `RES` between edges → `Y=0` and `FILL=0` immediately. After release, feed 1,0,1 → `Y=1` after the third edge and `MATCH_CNT=1`.
- Overlap: `OVERLAP=1`, feed 1,0,1,0,1 → `Y` is 0,0,1,0,1 after each edge and `MATCH_CNT=2`.
- Non-overlap: `OVERLAP=0`, feed 1,0,1,0,1,0,1 → `Y` high after edges 3 and 7 only, and `MATCH_CNT=2`.
- Stall and clear: feed 1,0, hold `EN=0` for 5 edges, then feed 1 → `Y=1`. Next, assert `CLR` together with `EN` and `I=1` → `Y=0`, `FILL=0`, `MATCH_CNT=0`.
- Wide pattern and saturation: `LEN=8`, `PATTERN`=8'hFF, `CNT_W=2`, `OVERLAP=1`, feed 12 ones → `Y` high from edge 8, `FILL` stops at 8, and `MATCH_CNT` saturates at 3.
- Build variant: without `SEQDET_MATCH_CNT_EN`, rerun the overlap scenario → `Y` is identical and `MATCH_CNT` stays 0.
